// File: rtl/wisc_pkg.sv
// Shared definitions for the decode->execute operand stage: widths, id/data
// types, the opcode set and the layout of the held pipeline entry.
package wisc_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_ID_W = 4;
    localparam int OPC_W    = 4;

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [OPC_W-1:0]    opc_t;

    // Named opcodes.
    // The stage itself only carries the opcode through, so any 4-bit value is legal.
    typedef enum logic [OPC_W-1:0] {
        OPC_ADD = 4'h0,
        OPC_SUB = 4'h1,
        OPC_AND = 4'h2,
        OPC_OR  = 4'h3,
        OPC_XOR = 4'h4,
        OPC_SLL = 4'h5,
        OPC_SRL = 4'h6,
        OPC_SRA = 4'h7,
        OPC_LDI = 4'h8,
        OPC_LD  = 4'h9,
        OPC_ST  = 4'hA,
        OPC_BEQ = 4'hB,
        OPC_BNE = 4'hC,
        OPC_JMP = 4'hD,
        OPC_NOP = 4'hE,
        OPC_HLT = 4'hF
    } opcode_e;

    // Everything the stage holds for one instruction.
    // The source ids are kept so that the held operands can follow writeback while stalled.
    typedef struct packed {
        data_t   op1;
        data_t   op2;
        reg_id_t rd;
        logic    we;
        opc_t    opcode;
        reg_id_t rs1;
        reg_id_t rs2;
    } held_t;

    // True when a writeback this cycle targets the given register.
    // R0 is an ordinary register, so it has no special case here.
    function automatic logic wb_hits(input logic wb_we, input reg_id_t wb_rd, input reg_id_t rs);
        return wb_we && (wb_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundles the decode-side, register-file, writeback and execute-side signals
// of the operand stage. The master side is the surrounding pipeline; the slave
// side is the stage itself.
interface id_ex_operand_stage_if;
    import wisc_pkg::*;

    // decode -> stage
    logic    in_valid;
    logic    in_ready;
    reg_id_t in_rs1;
    reg_id_t in_rs2;
    reg_id_t in_rd;
    logic    in_we;
    opc_t    in_opcode;

    // register file read ports
    reg_id_t rf_src1;
    reg_id_t rf_src2;
    data_t   rf_data1;
    data_t   rf_data2;

    // writeback port
    logic    wb_we;
    reg_id_t wb_rd;
    data_t   wb_data;

    // pipeline control
    logic    flush;

    // stage -> execute
    logic    out_valid;
    logic    out_ready;
    data_t   out_op1;
    data_t   out_op2;
    reg_id_t out_rd;
    logic    out_we;
    opc_t    out_opcode;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_we, in_opcode,
        input  in_ready,
        input  rf_src1, rf_src2,
        output rf_data1, rf_data2,
        output wb_we, wb_rd, wb_data,
        output flush,
        input  out_valid, out_op1, out_op2, out_rd, out_we, out_opcode,
        output out_ready
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_we, in_opcode,
        output in_ready,
        output rf_src1, rf_src2,
        input  rf_data1, rf_data2,
        input  wb_we, wb_rd, wb_data,
        input  flush,
        output out_valid, out_op1, out_op2, out_rd, out_we, out_opcode,
        input  out_ready
    );

endinterface

// File: rtl/id_ex_operand_stage_rf_bypass_mux.sv
// Selects writeback data over a register value when the writeback targets the
// same register id. It is used both to bypass a stale RF read at capture time
// and to refresh held operands while the stage is stalled.
module rf_bypass_mux
    import wisc_pkg::*;
(
    input  logic    wb_we,
    input  reg_id_t wb_rd,
    input  data_t   wb_data,
    input  reg_id_t rs,
    input  data_t   rf_data,
    output data_t   operand
);

    // Writeback wins whenever it targets this source register.
    always_comb begin
        operand = rf_data;
        if (wb_hits(wb_we, wb_rd, rs)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Decode->execute operand stage. It drives the RF read addresses straight from
// decode, captures both operands plus dest/opcode into a one-entry valid/ready
// register, and keeps the held operands in step with writeback while execute
// stalls.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   - on accept, an operand whose source matches this cycle's
//               writeback takes wb_data instead of the (stale) RF read data.
//   undefined - operands are always taken from the RF read data; any
//               same-cycle writeback hazard is interlocked upstream.
module id_ex_operand_stage
    import wisc_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    id_ex_operand_stage_if.slave bus
);

    held_t held;
    logic  held_valid;

    logic  in_ready;
    logic  accept;

    data_t cap_op1;
    data_t cap_op2;
    data_t ref_op1;
    data_t ref_op2;

    // The register file is read combinationally at the decode-side source ids.
    assign bus.rf_src1 = bus.in_rs1;
    assign bus.rf_src2 = bus.in_rs2;

    // A flush blocks intake outright; otherwise the slot is free when empty or draining.
    assign in_ready = !bus.flush && (!held_valid || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

`ifdef RF_BYPASS_EN
    rf_bypass_mux u_cap_mux1 (
        .wb_we   (bus.wb_we),
        .wb_rd   (bus.wb_rd),
        .wb_data (bus.wb_data),
        .rs      (bus.in_rs1),
        .rf_data (bus.rf_data1),
        .operand (cap_op1)
    );

    rf_bypass_mux u_cap_mux2 (
        .wb_we   (bus.wb_we),
        .wb_rd   (bus.wb_rd),
        .wb_data (bus.wb_data),
        .rs      (bus.in_rs2),
        .rf_data (bus.rf_data2),
        .operand (cap_op2)
    );
`else
    assign cap_op1 = bus.rf_data1;
    assign cap_op2 = bus.rf_data2;
`endif

    // Refresh candidates: the held operand, replaced by writeback when it targets the held source.
    rf_bypass_mux u_ref_mux1 (
        .wb_we   (bus.wb_we),
        .wb_rd   (bus.wb_rd),
        .wb_data (bus.wb_data),
        .rs      (held.rs1),
        .rf_data (held.op1),
        .operand (ref_op1)
    );

    rf_bypass_mux u_ref_mux2 (
        .wb_we   (bus.wb_we),
        .wb_rd   (bus.wb_rd),
        .wb_data (bus.wb_data),
        .rs      (held.rs2),
        .rf_data (held.op2),
        .operand (ref_op2)
    );

    // Pipeline register: flush squashes, accept captures, drain empties, stall refreshes.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid <= 1'b0;
            held       <= '0;
        end else if (bus.flush) begin
            held_valid <= 1'b0;
        end else if (accept) begin
            held_valid  <= 1'b1;
            held.op1    <= cap_op1;
            held.op2    <= cap_op2;
            held.rd     <= bus.in_rd;
            held.we     <= bus.in_we;
            held.opcode <= bus.in_opcode;
            held.rs1    <= bus.in_rs1;
            held.rs2    <= bus.in_rs2;
        end else if (held_valid && bus.out_ready) begin
            held_valid <= 1'b0;
        end else if (held_valid) begin
            held.op1 <= ref_op1;
            held.op2 <= ref_op2;
        end
    end

    // Execute sees only registered state, so out_ready never reaches the data outputs.
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = held_valid;
    assign bus.out_op1    = held.op1;
    assign bus.out_op2    = held.op2;
    assign bus.out_rd     = held.rd;
    assign bus.out_we     = held.we;
    assign bus.out_opcode = held.opcode;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed testbench for id_ex_operand_stage. A small register-file array
// answers the combinational RF reads; expected values are hand-computed.
// Build with RF_BYPASS_EN defined to check the capture bypass variant.
module tb_id_ex_operand_stage;
    import wisc_pkg::*;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    data_t rf_mem [16];

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rf_data1 = rf_mem[bus.rf_src1];
    assign bus.rf_data2 = rf_mem[bus.rf_src2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_rd     = '0;
        bus.in_we     = 1'b0;
        bus.in_opcode = '0;
        bus.wb_we     = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_valid actual=%0b required=0", bus.out_valid);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready actual=%0b required=1", bus.in_ready);
        end
        vectors++;
        if (bus.out_op1 !== 16'h0000 || bus.out_op2 !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ops actual=%h/%h required=0000/0000", bus.out_op1, bus.out_op2);
        end
        vectors++;
        if (bus.out_rd !== 4'h0 || bus.out_opcode !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rd_opc actual=%h/%h required=0/0", bus.out_rd, bus.out_opcode);
        end
        vectors++;
        if (bus.out_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_we actual=%0b required=0", bus.out_we);
        end
        rst = 1'b0;
    endtask

    task automatic test_capture();
        rf_mem[3]     = 16'h1234;
        bus.in_valid  = 1'b1;
        bus.in_rs1    = 4'd3;
        bus.in_rs2    = 4'd3;
        bus.in_rd     = 4'd7;
        bus.in_we     = 1'b1;
        bus.in_opcode = OPC_XOR;
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.rf_src1 !== 4'd3 || bus.rf_src2 !== 4'd3) begin
            miscompares++;
            $display("[TB] FAIL capture_rf_src actual=%h/%h required=3/3", bus.rf_src1, bus.rf_src2);
        end
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL capture_valid actual=%0b required=1", bus.out_valid);
        end
        vectors++;
        if (bus.out_op1 !== 16'h1234 || bus.out_op2 !== 16'h1234) begin
            miscompares++;
            $display("[TB] FAIL capture_ops actual=%h/%h required=1234/1234", bus.out_op1, bus.out_op2);
        end
        vectors++;
        if (bus.out_rd !== 4'd7 || bus.out_we !== 1'b1 || bus.out_opcode !== 4'h4) begin
            miscompares++;
            $display("[TB] FAIL capture_ctrl actual=%h/%0b/%h required=7/1/4", bus.out_rd, bus.out_we, bus.out_opcode);
        end
    endtask

    task automatic test_stall_refresh();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_rs1    = 4'd9;
        bus.in_rs2    = 4'd9;
        bus.wb_we     = 1'b1;
        bus.wb_rd     = 4'd3;
        bus.wb_data   = 16'hBEEF;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_in_ready actual=%0b required=0", bus.in_ready);
        end
        step();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_op1 !== 16'hBEEF || bus.out_op2 !== 16'hBEEF) begin
            miscompares++;
            $display("[TB] FAIL stall_refresh actual=%0b/%h/%h required=1/beef/beef", bus.out_valid, bus.out_op1, bus.out_op2);
        end
        bus.wb_we   = 1'b0;
        bus.wb_data = 16'h5555;
        step();
        vectors++;
        if (bus.out_op1 !== 16'hBEEF || bus.out_op2 !== 16'hBEEF) begin
            miscompares++;
            $display("[TB] FAIL stall_no_we actual=%h/%h required=beef/beef", bus.out_op1, bus.out_op2);
        end
        bus.wb_we   = 1'b1;
        bus.wb_rd   = 4'd4;
        bus.wb_data = 16'h7777;
        step();
        vectors++;
        if (bus.out_op1 !== 16'hBEEF || bus.out_op2 !== 16'hBEEF) begin
            miscompares++;
            $display("[TB] FAIL stall_other_rd actual=%h/%h required=beef/beef", bus.out_op1, bus.out_op2);
        end
        bus.wb_we     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drain_valid actual=%0b required=0", bus.out_valid);
        end
    endtask

    task automatic test_bypass();
        data_t exp_op1;
`ifdef RF_BYPASS_EN
        exp_op1 = 16'h00AA;
`else
        exp_op1 = 16'h0011;
`endif
        rf_mem[5]     = 16'h0011;
        rf_mem[6]     = 16'h0022;
        bus.in_valid  = 1'b1;
        bus.in_rs1    = 4'd5;
        bus.in_rs2    = 4'd6;
        bus.in_rd     = 4'd2;
        bus.in_opcode = OPC_ADD;
        bus.out_ready = 1'b1;
        bus.wb_we     = 1'b1;
        bus.wb_rd     = 4'd5;
        bus.wb_data   = 16'h00AA;
        step();
        bus.in_valid = 1'b0;
        bus.wb_we    = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_op1 !== exp_op1) begin
            miscompares++;
            $display("[TB] FAIL bypass_op1 actual=%0b/%h required=1/%h", bus.out_valid, bus.out_op1, exp_op1);
        end
        vectors++;
        if (bus.out_op2 !== 16'h0022) begin
            miscompares++;
            $display("[TB] FAIL bypass_op2 actual=%h required=0022", bus.out_op2);
        end
        step();
    endtask

    task automatic test_flush();
        rf_mem[1]     = 16'h1111;
        rf_mem[2]     = 16'h2222;
        bus.in_valid  = 1'b1;
        bus.in_rs1    = 4'd1;
        bus.in_rs2    = 4'd1;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_rs1    = 4'd2;
        bus.in_rs2    = 4'd2;
        bus.flush     = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_in_ready_stalled actual=%0b required=0", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_in_ready_draining actual=%0b required=0", bus.in_ready);
        end
        bus.out_ready = 1'b0;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_out_valid actual=%0b required=0", bus.out_valid);
        end
        step();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_no_capture actual=%0b required=0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            rf_mem[i] = 16'h1000 + 16'(i);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_rs1    = 4'(i);
            bus.in_rs2    = 4'(i);
            bus.in_rd     = 4'(i + 8);
            bus.in_opcode = 4'(i);
            #1;
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL b2b_in_ready[%0d] actual=%0b required=1", i, bus.in_ready);
            end
            step();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_op1 !== 16'h1000 + 16'(i) || bus.out_rd !== 4'(i + 8)) begin
                miscompares++;
                $display("[TB] FAIL b2b_out[%0d] actual=%0b/%h/%h required=1/%h/%h",
                         i, bus.out_valid, bus.out_op1, bus.out_rd, 16'h1000 + 16'(i), 4'(i + 8));
            end
        end
        bus.in_valid = 1'b0;
        step();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_drain actual=%0b required=0", bus.out_valid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 16; i++) begin
            rf_mem[i] = 16'hC000 + 16'(i);
        end
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_capture();
        test_stall_refresh();
        test_bypass();
        test_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
